// File: rtl/dot_pkg.sv
// Shared definitions for the dotProduct scratch-memory sequencers.
//   state_t         : burst sequencer states
//   RD_FIFO_DEPTH   : output FIFO depth of the read sequencer
//   MEM_RD_LATENCY  : scratch memory read latency in cycles (registered read)
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned RD_FIFO_DEPTH  = 4;
    localparam int unsigned MEM_RD_LATENCY = 1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead head data.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset; empties the FIFO
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   head_data  out  current head entry, valid whenever !empty
//   count      out  number of stored entries (0..DEPTH)
//   empty      out  no entries stored
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side sequencer for the dotProduct scratch memories. On an accepted start it reads
// `length` consecutive words from base_addr (wrapping at the top of memory) and streams them
// out on a valid/ready interface, flagging the final word with m_last. A small output FIFO
// absorbs the 1-cycle memory latency; reads are only issued when the FIFO is guaranteed to
// have room, so backpressure never drops data.
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start             burst request, sampled only in IDLE
//   base_addr, length burst address / word count, latched on accepted start
//   busy, done        busy in READ/DRAIN; done is a 1-cycle completion pulse
//   mem_read_en       memory read strobe
//   mem_read_address  memory read address
//   mem_data_out      memory read data, valid the cycle after mem_read_en
//   m_valid, m_ready  stream handshake
//   m_data, m_last    stream word and end-of-burst flag (0 while !m_valid)
module mem_stream_reader
    import dot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    // With a single-cycle memory, a read is in flight for exactly one cycle, so the
    // pending tracker is the registered read strobe plus its end-of-burst tag.
    logic                  rd_pend_q;
    logic                  rd_last_q;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_issue;
    logic                  pop;

    // Room must exist for every word already buffered or still in flight, plus this one.
    assign credit_ok  = (SUM_W'(fifo_count) + SUM_W'(rd_pend_q)) < SUM_W'(RD_FIFO_DEPTH);
    assign issue      = (state_q == READ) && (remain_q != '0) && credit_ok;
    assign last_issue = issue && (remain_q == LEN_WIDTH'(1));

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_last  = m_valid && fifo_head[DATA_WIDTH];
    assign pop     = m_valid && m_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = length;
                    state_d  = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - LEN_WIDTH'(1);
                end
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            rd_pend_q <= issue;
            rd_last_q <= last_issue;
        end
    end

    sync_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data ({rd_last_q, mem_data_out}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign busy             = (state_q == READ) || (state_q == DRAIN);
    assign done             = (state_q == DONE);
    assign mem_read_en      = issue;
    assign mem_read_address = addr_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic       busy;
    logic       done;
    logic       mem_read_en;
    logic [5:0] mem_read_address;
    logic [7:0] mem_data_out = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;

    mem_stream_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6),
        .LEN_WIDTH  (7)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mem_read_en      (mem_read_en),
        .mem_read_address (mem_read_address),
        .mem_data_out     (mem_data_out),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scratch memory with a registered read port.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (mem_read_en === 1'b1) mem_data_out <= mem[mem_read_address];
    end

    // Downstream ready generator.
    int rmode = 0;
    int rprob = 100;
    int rcnt  = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (rcnt % 3 == 0);
                2:       m_ready = ($urandom_range(99) < rprob);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Behavioural model: a burst is a list of words; the model counts reads issued,
    // words landed in the buffer and words accepted downstream.
    int         m_phase = 0;  // 0 idle, 1 burst in progress, 2 completion pulse
    int         m_base, m_len;
    int         issued, pushed, popped;
    logic [8:0] exp_words [64];
    int         addr_log [$];
    bit         was_reset = 0;

    always @(negedge clk) begin
        bit exp_rd, exp_valid, hs;
        if (rst_n !== 1'b1) begin
            m_phase = 0; m_len = 0; issued = 0; pushed = 0; popped = 0;
            was_reset = 1;
        end else begin
            if (was_reset) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rd_en", mem_read_en, 0);
                chk("rst_rd_addr", mem_read_address, 0);
                chk("rst_valid", m_valid, 0);
                chk("rst_data", m_data, 0);
                chk("rst_last", m_last, 0);
                was_reset = 0;
            end
            exp_rd    = (m_phase == 1) && (issued < m_len) && (issued - popped < 4);
            exp_valid = pushed > popped;
            chk("busy", busy, m_phase == 1);
            chk("done", done, m_phase == 2);
            chk("rd_en", mem_read_en, exp_rd);
            if (exp_rd) chk("rd_addr", mem_read_address, (m_base + issued) % 64);
            chk("m_valid", m_valid, exp_valid);
            if (exp_valid) begin
                chk("m_data", m_data, exp_words[popped][7:0]);
                chk("m_last", m_last, exp_words[popped][8]);
            end
            if (mem_read_en === 1'b1) addr_log.push_back(int'(mem_read_address));
            hs = exp_valid && (m_ready === 1'b1);
            case (m_phase)
                0: begin
                    if (start === 1'b1) begin
                        m_base = int'(base_addr);
                        m_len  = int'(length);
                        issued = 0; pushed = 0; popped = 0;
                        for (int i = 0; i < m_len; i++)
                            exp_words[i] = {(i == m_len - 1), mem[(m_base + i) % 64]};
                        m_phase = (m_len == 0) ? 2 : 1;
                    end
                end
                1: begin
                    pushed = issued;
                    if (exp_rd) issued++;
                    if (hs) begin
                        popped++;
                        if (popped == m_len) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            n++;
        end
        chk("done_timeout", seen, 1);
        cyc();
    endtask

    task automatic run_burst(input int b, input int l, input int mode);
        rmode = mode;
        start = 1'b1; base_addr = 6'(b); length = 7'(l);
        cyc();
        start = 1'b0;
        wait_done(5000);
        chk("words_delivered", popped, l);
    endtask

    // base=5 len=4, mem[a]=a+16: words 0x15..0x18 in cycles 3..6, done in cycle 7.
    task automatic directed_basic();
        for (int a = 0; a < 64; a++) mem[a] = 8'(a + 16);
        rmode = 0;
        start = 1'b1; base_addr = 6'd5; length = 7'd4;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("t1_rd_en", mem_read_en, (k >= 1 && k <= 4));
            chk("t1_valid", m_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("t1_data", m_data, 32'h12 + k);
            chk("t1_last", m_last, k == 6);
            chk("t1_done", done, k == 7);
            chk("t1_busy", busy, k <= 6);
        end
        cyc();
    endtask

    initial begin
        int b, l;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        for (int a = 0; a < 64; a++) mem[a] = 8'(a + 16);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        directed_basic();

        // Address wrap at the top of memory.
        addr_log.delete();
        run_burst(62, 4, 0);
        chk("wrap_n", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("wrap_a0", addr_log[0], 62);
            chk("wrap_a1", addr_log[1], 63);
            chk("wrap_a2", addr_log[2], 0);
            chk("wrap_a3", addr_log[3], 1);
        end

        // Zero-length burst: done in cycle 1, nothing else.
        start = 1'b1; base_addr = 6'd9; length = 7'd0;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("len0_done", done, k == 1);
            chk("len0_busy", busy, 0);
            chk("len0_rd_en", mem_read_en, 0);
            chk("len0_valid", m_valid, 0);
        end
        cyc();

        // Stalling consumer.
        run_burst(30, 8, 1);

        // Start while busy is ignored.
        addr_log.delete();
        rmode = 0;
        start = 1'b1; base_addr = 6'd10; length = 7'd6;
        cyc();
        start = 1'b1; base_addr = 6'd40; length = 7'd3;
        cyc();
        start = 1'b0;
        wait_done(500);
        chk("ign_n", addr_log.size(), 6);
        for (int i = 0; i < addr_log.size(); i++) chk("ign_addr", addr_log[i], 10 + i);

        // Reset mid-burst with two words buffered.
        rmode = 3;
        start = 1'b1; base_addr = 6'd20; length = 7'd8;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", m_valid, 1);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd_en", mem_read_en, 0);
        chk("post_rst_data", m_data, 0);
        cyc();
        directed_basic();

        // Randomized bursts.
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
            b = $urandom_range(63);
            l = ($urandom_range(9) == 0) ? 64 : $urandom_range(20);
            rprob = $urandom_range(100, 20);
            rmode = $urandom_range(2);
            start = 1'b1; base_addr = 6'(b); length = 7'(l);
            cyc();
            start = 1'b0;
            if (l >= 2 && $urandom_range(3) == 0) begin
                start = 1'b1; base_addr = 6'($urandom); length = 7'($urandom_range(64));
                cyc();
                start = 1'b0;
            end
            if (l >= 1 && $urandom_range(7) == 0) begin
                repeat ($urandom_range(l)) cyc();
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
                cyc();
            end else begin
                wait_done(5000);
                chk("rand_words", popped, l);
            end
        end

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
